// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store size
// codes and the responder FSM state encoding.
package data_mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Size codes outside the five RV32I load forms.
    function automatic logic is_illegal_funct3(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Combinational byte-lane steering: store byte enables and lane-positioned
// write word, load lane extraction with sign/zero extension, misalignment flag.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  byte_sel,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] write_word,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statements can leave a value held (a latch).
    always_comb begin
        byte_en    = 4'b0000;
        write_word = wdata;
        unique case (funct3)
            F3_B: begin
                byte_en    = 4'b0001 << byte_sel;
                write_word = {4{wdata[7:0]}};
            end
            F3_H: begin
                byte_en    = byte_sel[1] ? 4'b1100 : 4'b0011;
                write_word = {2{wdata[15:0]}};
            end
            F3_W: begin
                byte_en    = 4'b1111;
                write_word = wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_byte = raw_word[7:0];
        case (byte_sel)
            2'd0: lane_byte = raw_word[7:0];
            2'd1: lane_byte = raw_word[15:8];
            2'd2: lane_byte = raw_word[23:16];
            2'd3: lane_byte = raw_word[31:24];
            default: ;
        endcase
        lane_half = byte_sel[1] ? raw_word[31:16] : raw_word[15:0];

        load_data = 32'd0;
        case (funct3)
            F3_B:  load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU: load_data = {24'd0, lane_byte};
            F3_H:  load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU: load_data = {16'd0, lane_half};
            F3_W:  load_data = raw_word;
            default: ;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        if ((funct3 == F3_H || funct3 == F3_HU) && byte_sel[0])
            misaligned = 1'b1;
        else if (funct3 == F3_W && byte_sel != 2'd0)
            misaligned = 1'b1;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store per handshake,
// performs it after a fixed latency and holds the response until taken.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 10,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int                IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);
    localparam logic [3:0]        CNT_LOAD   = 4'(LATENCY - 1);

    state_t state, next_state;
    logic [3:0] cnt;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [2:0]        cap_funct3;

    logic [31:0] mem [DEPTH_WORDS];

    logic accept, enter_resp;

    // With LATENCY == 1 the access edge is the acceptance edge, so the live
    // request is used while idle and the captured copy afterwards.
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [2:0]        cur_funct3;

    assign cur_we     = (state == IDLE) ? req_we     : cap_we;
    assign cur_addr   = (state == IDLE) ? req_addr   : cap_addr;
    assign cur_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;
    assign cur_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;

    logic [IDX_W-1:0] word_idx;
    logic [3:0]       byte_en;
    logic [31:0]      write_word, load_data;
    logic             misaligned, req_err;

    assign word_idx = cur_addr[IDX_W+1:2];

    mem_lane_align u_align (
        .byte_sel   (cur_addr[1:0]),
        .funct3     (cur_funct3),
        .wdata      (cur_wdata),
        .raw_word   (mem[word_idx]),
        .byte_en    (byte_en),
        .write_word (write_word),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign req_err = misaligned
                   || is_illegal_funct3(cur_funct3)
                   || (cur_we && cur_funct3[2])
                   || ({1'b0, cur_addr} >= ADDR_LIMIT);

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY > 1) begin
                        next_state = WAIT;
                    end else begin
                        next_state = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    next_state = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign resp_valid = (state == RESP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= 32'd0;
            cap_funct3 <= 3'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt        <= CNT_LOAD;
                cap_we     <= req_we;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
                cap_funct3 <= req_funct3;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_err   <= req_err;
                resp_rdata <= (req_err || cur_we) ? 32'd0 : load_data;
            end else if (state == RESP && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= 32'd0;
            end
        end
    end

    // NOTE: the storage array is cleared on reset, so it must sit in its own
    // reset-aware process; a reset aborting a pending store leaves it unwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= 32'd0;
        end else if (enter_resp && cur_we && !req_err) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b])
                    mem[word_idx][8*b +: 8] <= write_word[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH 64, LATENCY 2).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(64), .ADDR_W(10), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one request, wait for its response and return it; lat counts
    // cycles from the handshake cycle to the first cycle with resp_valid.
    task automatic transact(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                            output int lat);
        int guard;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] rd;
        logic        er;
        int          lat;
        transact(v.we, v.addr, v.wdata, v.f3, rd, er, lat);
        check({v.name, " latency"}, 32'(lat), 32'd2);
        check({v.name, " rdata"}, rd, v.exp_rdata);
        check({v.name, " err"}, {31'd0, er}, {31'd0, v.exp_err});
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vecs.push_back('{"SW 0x10",     1'b1, 10'h010, 32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0});
        vecs.push_back('{"LW 0x10",     1'b0, 10'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"LB 0x13",     1'b0, 10'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0});
        vecs.push_back('{"LBU 0x13",    1'b0, 10'h013, 32'h0,        3'b100, 32'h000000DE, 1'b0});
        vecs.push_back('{"LH 0x12",     1'b0, 10'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0});
        vecs.push_back('{"LHU 0x10",    1'b0, 10'h010, 32'h0,        3'b101, 32'h0000BEEF, 1'b0});
        vecs.push_back('{"SB 0x11",     1'b1, 10'h011, 32'h12345677, 3'b000, 32'h00000000, 1'b0});
        vecs.push_back('{"LW after SB", 1'b0, 10'h010, 32'h0,        3'b010, 32'hDEAD77EF, 1'b0});
        vecs.push_back('{"LB 0x11",     1'b0, 10'h011, 32'h0,        3'b000, 32'h00000077, 1'b0});
        vecs.push_back('{"SH 0x12",     1'b1, 10'h012, 32'h0000CAFE, 3'b001, 32'h00000000, 1'b0});
        vecs.push_back('{"LW after SH", 1'b0, 10'h010, 32'h0,        3'b010, 32'hCAFE77EF, 1'b0});
        vecs.push_back('{"LW 0x12 mis", 1'b0, 10'h012, 32'h0,        3'b010, 32'h00000000, 1'b1});
        vecs.push_back('{"LH 0x11 mis", 1'b0, 10'h011, 32'h0,        3'b001, 32'h00000000, 1'b1});
        vecs.push_back('{"SB f3=100",   1'b1, 10'h010, 32'h000000FF, 3'b100, 32'h00000000, 1'b1});
        vecs.push_back('{"SH 0x13 mis", 1'b1, 10'h013, 32'h0000FFFF, 3'b001, 32'h00000000, 1'b1});
        vecs.push_back('{"LD f3=011",   1'b0, 10'h010, 32'h0,        3'b011, 32'h00000000, 1'b1});
        vecs.push_back('{"LW 0x100",    1'b0, 10'h100, 32'h0,        3'b010, 32'h00000000, 1'b1});
        vecs.push_back('{"LW unchanged",1'b0, 10'h010, 32'h0,        3'b010, 32'hCAFE77EF, 1'b0});

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_err", {31'd0, resp_err}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response held under back-pressure.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 10'h010;
        req_funct3 = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("hold latency", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold resp_valid", {31'd0, resp_valid}, 32'd1);
            check("hold resp_rdata", resp_rdata, 32'hCAFE77EF);
            check("hold req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("post-handshake req_ready", {31'd0, req_ready}, 32'd1);
        check("post-handshake resp_valid", {31'd0, resp_valid}, 32'd0);
        check("post-handshake resp_rdata", resp_rdata, 32'd0);

        // Reset during WAIT of a store aborts it.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 10'h020;
        req_wdata  = 32'h00000055;
        req_funct3 = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        check("in WAIT req_ready", {31'd0, req_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid-op reset req_ready", {31'd0, req_ready}, 32'd1);
        check("mid-op reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("mid-op reset resp_rdata", resp_rdata, 32'd0);
        check("mid-op reset resp_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_vec('{"LW 0x20 after reset", 1'b0, 10'h020, 32'h0, 3'b010, 32'h00000000, 1'b0});
        run_vec('{"LW 0x10 cleared",     1'b0, 10'h010, 32'h0, 3'b010, 32'h00000000, 1'b0});

        // Stores still work after the aborted one.
        transact(1'b1, 10'h020, 32'hA5A5A5A5, 3'b010, rd, er, lat);
        transact(1'b0, 10'h020, 32'h0, 3'b010, rd, er, lat);
        check("LW 0x20 after SW", rd, 32'hA5A5A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
